// File: rtl/driver_matriz_generico.sv
// Row-scanning LED dot-matrix driver with per-frame PWM brightness, row blanking
// and a double-buffered frame so pattern updates never tear mid-scan.
module driver_matriz_generico #(
  parameter int LINHAS       = 8,
  parameter int COLUNAS      = 8,
  parameter int BRILHO_BITS  = 3,
  parameter int SUB_DIV      = 782,
  parameter bit ATIVO_LINHA  = 1'b1,
  parameter bit ATIVO_COLUNA = 1'b0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       habilita,
  input  logic [LINHAS*COLUNAS-1:0]  padrao,
  input  logic                       atualiza,
  input  logic [BRILHO_BITS-1:0]     brilho,
  output logic [LINHAS-1:0]          linhas,
  output logic [COLUNAS-1:0]         colunas,
  output logic                       pendente,
  output logic                       troca,
  output logic                       fim_quadro
);

  localparam int DIV_W = $clog2(SUB_DIV);
  localparam int LIN_W = $clog2(LINHAS);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SUB_DIV - 1);
  localparam logic [LIN_W-1:0] LIN_MAX = LIN_W'(LINHAS - 1);

  logic [LINHAS*COLUNAS-1:0] buf_pend_q, buf_pend_d;
  logic [LINHAS*COLUNAS-1:0] buf_disp_q, buf_disp_d;
  logic [BRILHO_BITS-1:0]    brilho_q, brilho_d;
  logic [DIV_W-1:0]          cont_div_q, cont_div_d;
  logic [BRILHO_BITS-1:0]    fase_q, fase_d;
  logic [LIN_W-1:0]          linha_q, linha_d;
  logic                      pendente_q, pendente_d;
  logic [LINHAS-1:0]         linhas_q, linhas_d;
  logic [COLUNAS-1:0]        colunas_q, colunas_d;

  logic                      fim_div, fim_fase, fim_linha, blank;
  logic [COLUNAS-1:0]        row_bits, col_on;
  logic [LINHAS-1:0]         row_sel;

  always_comb begin
    fim_div    = (cont_div_q == DIV_MAX);
    fim_fase   = fim_div && (fase_q == '1);
    fim_linha  = fim_fase && (linha_q == LIN_MAX);
    fim_quadro = habilita && fim_linha;
    troca      = fim_quadro && pendente_q;

    cont_div_d = '0;
    fase_d     = '0;
    linha_d    = '0;
    if (habilita) begin
      cont_div_d = fim_div ? '0 : cont_div_q + 1'b1;
      fase_d     = fim_div ? fase_q + 1'b1 : fase_q;
      linha_d    = linha_q;
      if (fim_fase) linha_d = fim_linha ? '0 : linha_q + 1'b1;
    end

    // Swap uses the old pending frame even if atualiza lands on the same clock.
    buf_disp_d = troca ? buf_pend_q : buf_disp_q;
    brilho_d   = fim_quadro ? brilho : brilho_q;
    buf_pend_d = atualiza ? padrao : buf_pend_q;
    pendente_d = atualiza || (pendente_q && !troca);

    row_bits = buf_disp_q[linha_q*COLUNAS +: COLUNAS];
    blank    = (fase_q == '0) && (cont_div_q == '0);
    row_sel  = '0;
    row_sel[linha_q] = habilita;
    col_on   = (habilita && !blank && (fase_q <= brilho_q)) ? row_bits : '0;
    linhas_d  = ATIVO_LINHA  ? row_sel : ~row_sel;
    colunas_d = ATIVO_COLUNA ? col_on  : ~col_on;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      buf_pend_q <= '0;
      buf_disp_q <= '0;
      brilho_q   <= '0;
      cont_div_q <= '0;
      fase_q     <= '0;
      linha_q    <= '0;
      pendente_q <= 1'b0;
      linhas_q   <= {LINHAS{~ATIVO_LINHA}};
      colunas_q  <= {COLUNAS{~ATIVO_COLUNA}};
    end else begin
      buf_pend_q <= buf_pend_d;
      buf_disp_q <= buf_disp_d;
      brilho_q   <= brilho_d;
      cont_div_q <= cont_div_d;
      fase_q     <= fase_d;
      linha_q    <= linha_d;
      pendente_q <= pendente_d;
      linhas_q   <= linhas_d;
      colunas_q  <= colunas_d;
    end
  end

  assign linhas   = linhas_q;
  assign colunas  = colunas_q;
  assign pendente = pendente_q;

endmodule

// File: tb/tb_driver_matriz_generico.sv
// Scoreboard bench for driver_matriz_generico on a 4x4 matrix, 4 phases of 2 clocks
// (8-clock row slot, 32-clock frame).
module tb_driver_matriz_generico;

  logic        clock, reset, habilita, atualiza;
  logic [15:0] padrao;
  logic [1:0]  brilho;
  logic [3:0]  linhas, colunas;
  logic        pendente, troca, fim_quadro;

  driver_matriz_generico #(
    .LINHAS(4), .COLUNAS(4), .BRILHO_BITS(2), .SUB_DIV(2),
    .ATIVO_LINHA(1'b1), .ATIVO_COLUNA(1'b0)
  ) dut (
    .clock(clock), .reset(reset), .habilita(habilita), .padrao(padrao),
    .atualiza(atualiza), .brilho(brilho), .linhas(linhas), .colunas(colunas),
    .pendente(pendente), .troca(troca), .fim_quadro(fim_quadro)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0] lin;
    logic [3:0] col;
    logic       pend;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: position within the 32-clock frame plus buffers.
  int          m_pos = 0;
  logic [15:0] m_pend_buf = '0, m_disp = '0;
  logic        m_pend = 1'b0;
  logic [1:0]  m_bq = '0;

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_vec++;
    if (obs !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", tag, obs, req, $time);
    end
  endtask

  task automatic step();
    exp_t e;
    int   row, ph, slot;
    logic fim, tro;
    logic [3:0] on;
    #1;
    slot = m_pos % 8;
    row  = m_pos / 8;
    ph   = slot / 2;
    fim  = habilita && (m_pos == 31);
    tro  = fim && m_pend;
    verifica("fim_quadro", fim_quadro, fim);
    verifica("troca", troca, tro);

    on = '0;
    if (habilita && slot != 0 && ph <= int'(m_bq))
      on = m_disp[row*4 +: 4];
    if (reset) begin
      e.lin = 4'b0000; e.col = 4'b1111; e.pend = 1'b0;
    end else begin
      e.lin  = habilita ? 4'(1 << row) : 4'b0000;
      e.col  = ~on;
      e.pend = atualiza || (m_pend && !tro);
    end
    exp_q.push_back(e);

    if (reset) begin
      m_pos = 0; m_pend_buf = '0; m_disp = '0; m_pend = 1'b0; m_bq = '0;
    end else begin
      if (tro) m_disp = m_pend_buf;
      if (fim) m_bq = brilho;
      if (atualiza) m_pend_buf = padrao;
      m_pend = atualiza || (m_pend && !tro);
      m_pos  = habilita ? (m_pos + 1) % 32 : 0;
    end

    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    verifica("linhas", linhas, e.lin);
    verifica("colunas", colunas, e.col);
    verifica("pendente", pendente, e.pend);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_until(input int p);
    for (int i = 0; i < 100 && m_pos != p; i++) step();
  endtask

  task automatic pulse_atualiza(input logic [15:0] img);
    padrao = img; atualiza = 1'b1;
    step();
    atualiza = 1'b0;
  endtask

  initial begin
    reset = 1'b1; habilita = 1'b0; atualiza = 1'b0; padrao = '0; brilho = '0;
    repeat (2) @(posedge clock);
    #1;
    step();
    reset = 1'b0;
    habilita = 1'b1;

    // Single frame: diagonal at full brightness
    brilho = 2'd3;
    pulse_atualiza(16'h8421);
    run(75);

    // Reset mid-scan with a non-empty display buffer
    run_until(13);
    reset = 1'b1;
    step();
    verifica("rst_linhas", linhas, 4'b0000);
    verifica("rst_colunas", colunas, 4'b1111);
    verifica("rst_pendente", pendente, 1'b0);
    reset = 1'b0;
    step();
    verifica("rst_row0", linhas, 4'b0001);
    verifica("rst_cols_off", colunas, 4'b1111);
    run(40);

    // Brightness: minimum duty, then a mid-frame change
    brilho = 2'd0;
    pulse_atualiza(16'hFFFF);
    run_until(0);
    run(32);
    run_until(12);
    brilho = 2'd2;
    run(70);

    // Overwrite within a frame, then collision on the boundary clock
    run_until(3);
    pulse_atualiza(16'h1234);
    run(5);
    pulse_atualiza(16'h5678);
    run_until(31);
    pulse_atualiza(16'h9ABC);
    verifica("collide_pend", pendente, 1'b1);
    run(70);

    // Disable mid-row 2, capture while disabled, re-enable
    run_until(20);
    habilita = 1'b0;
    run(5);
    pulse_atualiza(16'h0F0F);
    run(10);
    habilita = 1'b1;
    step();
    verifica("reen_row0", linhas, 4'b0001);
    run(70);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/driver_matriz_generico.md
# driver_matriz_generico

Parametrised row-scanning driver for common-row LED dot matrices, generalising the fixed 8x8 matrix driver used by the game top level. It scans `LINHAS` rows by `COLUNAS` columns, applies per-frame PWM brightness with row blanking, and double-buffers the frame so pattern updates never tear mid-scan. It sits between the game datapath/top-level pattern muxes and the matrix pins, one instance per physical matrix (piece and map).

## Interface

**Parameters**

- `LINHAS`, 8: number of rows scanned, ≥2.
- `COLUNAS`, 8: number of columns, ≥1.
- `BRILHO_BITS`, 3: brightness resolution; `2**BRILHO_BITS` PWM phases per row slot.
- `SUB_DIV`, 782: clocks per PWM phase, ≥2. Row slot = `SUB_DIV*2**BRILHO_BITS` clocks.
- `ATIVO_LINHA`, 1: pin level that selects a row.
- `ATIVO_COLUNA`, 0: pin level that lights a column.

**Ports**

- `clock` in 1: system clock (50 MHz).
- `reset` in 1: synchronous, active-high.
- `habilita` in 1: 1 = scan; 0 = blank and hold counters at 0.
- `padrao` in `LINHAS*COLUNAS`: frame image. Row r = `padrao[r*COLUNAS +: COLUNAS]`; bit c = column c; 1 = LED on.
- `atualiza` in 1: one-cycle strobe that captures `padrao` into the pending buffer.
- `brilho` in `BRILHO_BITS`: on-phases minus 1 (0 = 1/2^B duty, max = full).
- `linhas` out `LINHAS`: row pins, registered.
- `colunas` out `COLUNAS`: column pins, registered.
- `pendente` out 1: pending buffer holds a frame not yet displayed.
- `troca` out 1: one-cycle pulse when pending is copied to display.
- `fim_quadro` out 1: one-cycle pulse on the last clock of the last row slot.

## Operation

**Storage**

- Registers: `buf_pend`, `buf_disp`, `brilho_q`.
- Counters: `cont_div` (0..SUB_DIV-1), `fase` (0..2^B-1), `linha` (0..LINHAS-1).

**Reset** (all applied next edge)

- `buf_*` and `brilho_q` = 0; counters = 0.
- `pendente` = 0, `troca` = 0, `fim_quadro` = 0.
- `linhas` = all `~ATIVO_LINHA`; `colunas` = all `~ATIVO_COLUNA`.
- Reset mid-frame discards both buffers and any pending frame.

**Scan**

- `cont_div` wraps at SUB_DIV-1 and then increments `fase`.
- `fase` wraps at 2^B-1 and then increments `linha`.
- `linha` wraps at LINHAS-1 back to 0.
- Row `linha` is driven active; all other rows are inactive.

**Column drive** for the current row, column c is active only when all of these hold:

- `buf_disp` bit (linha, c) = 1;
- `fase` ≤ `brilho_q`;
- not in blanking. Blanking is the first clock of each row slot (`fase`=0, `cont_div`=0), with all columns inactive.

**Brightness**

- `brilho_q` loads `brilho` on the frame-boundary clock (same cycle as `fim_quadro`).
- Brightness changes therefore take effect only at frame start.

**Double buffer**

- `atualiza`=1 writes `padrao` into `buf_pend` and sets `pendente`=1.
- A repeat `atualiza` while pending overwrites `buf_pend`; last write wins.
- On the frame-boundary clock, if `pendente`=1: `buf_disp` ← `buf_pend`, `troca` pulses, and `pendente` clears.
- `atualiza` on the boundary clock:
  - the swap uses the old `buf_pend`;
  - the new data is written to `buf_pend`;
  - `pendente` stays 1.

**Disable**

- `habilita`=0: counters are held at 0 and outputs go inactive.
- `fim_quadro` and `troca` do not fire while disabled.
- `atualiza` still captures into `buf_pend`.
- On re-enable, scanning starts at row 0, phase 0.

## Timing

- Row slot = `SUB_DIV*2^BRILHO_BITS` clocks. Frame = `LINHAS` × row slot.
- With defaults, a frame is 50 048 clocks (≈1.0 ms at 50 MHz).
- `linhas`/`colunas` lag the counter state by exactly 1 clock (registered). `fim_quadro`/`troca` are not delayed.
- Update latency: `atualiza` at cycle t becomes visible in the first frame that starts after the next `fim_quadro`, plus 1 output register cycle.
- Worst case is one full frame + 1 clock.
- Duty per row is `(brilho+1)/2^B` of the slot, minus 1 blanking clock.
- At most one row is active in any cycle, including across row transitions.

## Test plan

All scenarios use LINHAS=4, COLUNAS=4, BRILHO_BITS=2, SUB_DIV=2, ATIVO_LINHA=1, ATIVO_COLUNA=0. This gives a row slot of 8 clocks and a frame of 32 clocks.

- **Reset.** Assert `reset` mid-scan with `buf_disp`≠0. Required:
  - next edge: `linhas`=4'b0000, `colunas`=4'b1111, `pendente`=0;
  - after release: row 0 active 1 clock later, all columns still off (buffer cleared).
- **Single frame.** `padrao`=16'h8421, `atualiza` pulse, `brilho`=3. Required:
  - `pendente`=1 until `fim_quadro`, then `troca` pulses on that same cycle;
  - next frame, row r lights only column r: `colunas`=~(1<<r);
  - each row slot has 1 blanking clock then 7 active clocks.
- **Brightness.** `padrao`=16'hFFFF, `brilho`=0. Required:
  - columns = 4'b0000 on clocks 1 of each slot and 4'b1111 otherwise (`fase`0 only, minus blanking);
  - change `brilho` to 2 mid-frame: duty changes only after the next `fim_quadro`.
- **Overwrite and boundary collision.**
  - Two `atualiza` (A, then B) in one frame: only B is displayed.
  - `atualiza` C on the `fim_quadro` cycle: B is swapped in, `pendente` stays 1, C is displayed one frame later.
- **Disable.** Drop `habilita` mid-row 2 with `atualiza` D while disabled. Required:
  - while disabled: all outputs inactive, no `fim_quadro`;
  - on re-enable: row 0 is first, and D swaps in at the first subsequent `fim_quadro` (every 32 clocks).
